// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_stage_pkg;

  localparam int SRAM_DW          = 16;
  localparam int DEF_ADDR_BASE    = 1024;
  localparam int DEF_SRAM_AW      = 18;
  localparam int DEF_WAIT_CYCLES  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Phase down-counter width; at least one bit even when there are no wait cycles.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// EXE/MEM -> MEM/WB pipeline bundle seen by the MEM-stage SRAM controller.
interface mem_stage_sram_ctrl_if;

  logic        wb_en_in;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [4:0]  dest_in;

  logic        ready;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_result_out;
  logic [4:0]  dest_out;
  logic [31:0] mem_read_value;

  // A request (mem_r_en|mem_w_en) is held stable by the producer until ready=1 is
  // seen on a rising edge; ready=1 with a load marks mem_read_value valid that cycle.
  modport master (
    output wb_en_in, mem_r_en, mem_w_en, alu_result, st_val, dest_in,
    input  ready, wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_read_value
  );

  modport slave (
    input  wb_en_in, mem_r_en, mem_w_en, alu_result, st_val, dest_in,
    output ready, wb_en_out, mem_r_en_out, alu_result_out, dest_out, mem_read_value
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_cache.sv
// One-entry read cache (valid, word tag, data); present only when SRAM_CACHE_EN is defined.
`ifdef SRAM_CACHE_EN
module mem_read_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_lookup_tag,
  output logic        o_hit,
  output logic [31:0] o_data,
  input  logic        i_fill_en,
  input  logic        i_wt_en,
  input  logic [29:0] i_tag,
  input  logic [31:0] i_data
);

  logic        r_valid;
  logic [29:0] r_tag;
  logic [31:0] r_data;

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

  // Loads allocate unconditionally; stores only refresh an entry they already match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill_en) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end else if (i_wt_en && r_valid && (r_tag == i_tag)) begin
      r_data  <= i_data;
    end
  end

endmodule
`endif

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: 32-bit loads/stores as two half-word SRAM phases, freezing the pipe.
// Optional one-entry read cache enabled by defining SRAM_CACHE_EN.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int SRAM_AW     = DEF_SRAM_AW,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  mem_stage_sram_ctrl_if.slave pipe,
  output logic [SRAM_AW-1:0]  sram_addr,
  inout  wire  [SRAM_DW-1:0]  sram_dq,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic [1:0]          o_dbg_state
);

  localparam int             CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WAIT_CYCLES);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [SRAM_AW-1:0]  r_addr;
  logic                r_store;
  logic [31:0]         r_wdata;
  logic [15:0]         r_lo;
  logic [31:0]         r_rdata;

  logic        w_req;
  logic [31:0] w_offset;
  logic [29:0] w_word;
  logic        w_active;
  logic        w_last;
  logic        w_hit;
  logic [31:0] w_cache_data;
  logic        w_unused_bits;

  assign w_req         = pipe.mem_r_en | pipe.mem_w_en;
  assign w_offset      = pipe.alu_result - 32'(ADDR_BASE);
  assign w_word        = w_offset[31:2];
  assign w_unused_bits = ^{w_offset[1:0], w_word};
  assign w_active      = (r_state == LO) || (r_state == HI);
  assign w_last        = (r_cnt == '0);

`ifdef SRAM_CACHE_EN
  logic w_cache_hit;

  mem_read_cache u_cache (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_tag (w_word),
    .o_hit        (w_cache_hit),
    .o_data       (w_cache_data),
    .i_fill_en    ((r_state == DONE) && !r_store),
    .i_wt_en      ((r_state == DONE) && r_store),
    .i_tag        (w_word),
    .i_data       (r_store ? r_wdata : r_rdata)
  );

  // Only a pure load in IDLE may be answered from the cache; both-enables is a store.
  assign w_hit = w_cache_hit && pipe.mem_r_en && !pipe.mem_w_en && (r_state == IDLE);
`else
  assign w_hit        = 1'b0;
  assign w_cache_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            r_state <= LO;
            r_cnt   <= CNT_LOAD;
            r_addr  <= {w_word[SRAM_AW-2:0], 1'b0};
            r_store <= pipe.mem_w_en;
            r_wdata <= pipe.st_val;
          end
        end
        LO: begin
          if (w_last) begin
            r_state   <= HI;
            r_cnt     <= CNT_LOAD;
            r_addr[0] <= 1'b1;
            if (!r_store) r_lo <= sram_dq;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        HI: begin
          if (w_last) begin
            r_state <= DONE;
            // Publish the whole word at once so mem_read_value never shows a half-updated load.
            if (!r_store) r_rdata <= {sram_dq, r_lo};
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write strobe releases one cycle early in each phase so data is stable at the rising edge.
  assign sram_we_n = !(w_active && r_store && (!w_last || (WAIT_CYCLES == 0)));
  assign sram_oe_n = !(w_active && !r_store);
  assign sram_dq   = (w_active && r_store) ?
                     ((r_state == HI) ? r_wdata[31:16] : r_wdata[15:0]) : {SRAM_DW{1'bz}};
  assign sram_addr = r_addr;

  assign pipe.ready          = !w_req || (r_state == DONE) || w_hit;
  assign pipe.wb_en_out      = pipe.wb_en_in;
  assign pipe.mem_r_en_out   = pipe.mem_r_en;
  assign pipe.alu_result_out = pipe.alu_result;
  assign pipe.dest_out       = pipe.dest_in;
  assign pipe.mem_read_value = w_hit ? w_cache_data : r_rdata;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed vector table, random traffic, mid-access reset.
module tb_mem_stage_sram_ctrl;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [1:0]  dbg_state;

  mem_stage_sram_ctrl_if pipe();

  mem_stage_sram_ctrl #(
    .ADDR_BASE   (BASE),
    .SRAM_AW     (AW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe        (pipe),
    .sram_addr   (sram_addr),
    .sram_dq     (sram_dq),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model ----------------
  logic [15:0] sram_mem [0:255];
  wire         unused_addr_hi = ^sram_addr[AW-1:8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= 16'h0000;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[7:0]] <= sram_dq;
    end
  end

  assign sram_dq = (!sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'bz;

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:63];
  logic        c_valid;
  logic [29:0] c_tag;
  int          n_checks;
  int          n_errors;

  typedef struct {
    logic [1:0]  op;       // 0 none, 1 load, 2 store, 3 both (store)
    logic [31:0] addr;
    logic [31:0] data;
    logic        wb;
    logic [4:0]  dest;
    logic [31:0] exp_val;  // expected load data
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic wb, input logic [4:0] dest);
    pipe.mem_r_en   = op[0];
    pipe.mem_w_en   = op[1];
    pipe.alu_result = addr;
    pipe.st_val     = data;
    pipe.wb_en_in   = wb;
    pipe.dest_in    = dest;
  endtask

  task automatic model_reset();
    c_valid = 1'b0;
    c_tag   = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
  endtask

  // One pipeline access: drive after a rising edge, then watch ready on falling edges.
  task automatic run_access(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic wb, input logic [4:0] dest, input logic [31:0] exp_val);
    logic [29:0] word;
    logic        is_store, is_load, hit, done;
    int          low, we_cnt, oe_cnt, exp_low, exp_we, exp_oe;
    logic [31:0] exp_rd;
    word     = 30'((addr - BASE) >> 2);
    is_store = op[1];
    is_load  = (op == 2'd1);
`ifdef SRAM_CACHE_EN
    hit = is_load && c_valid && (c_tag == word);
`else
    hit = 1'b0;
`endif
    exp_low = (op == 2'd0 || hit) ? 0 : 2 * W + 3;
    exp_we  = is_store ? ((W == 0) ? 2 : 2 * W) : 0;
    exp_oe  = (is_load && !hit) ? 2 * (W + 1) : 0;
    if (is_load) exp_q.push_back(exp_val);

    @(posedge clk); #1;
    drive(op, addr, data, wb, dest);
    low = 0; we_cnt = 0; oe_cnt = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (pipe.ready) done = 1'b1;
      else low++;
    end
    check("ready_timeout", {31'd0, done}, 32'd1);
    check("ready_low_cycles", low, exp_low);
    check("we_strobes", we_cnt, exp_we);
    check("oe_strobes", oe_cnt, exp_oe);
    check("passthru", {pipe.wb_en_out, pipe.mem_r_en_out, pipe.dest_out, pipe.alu_result_out},
          {wb, op[0], dest, addr});
    if (is_load) begin
      exp_rd = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      check("load_data", pipe.mem_read_value, exp_rd);
      if (!hit) begin c_valid = 1'b1; c_tag = word; end
    end
    if (is_store) begin
      @(posedge clk); #1;
      drive(2'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      check("sram_lo_half", {16'd0, sram_mem[8'({word[6:0], 1'b0})]}, {16'd0, data[15:0]});
      check("sram_hi_half", {16'd0, sram_mem[8'({word[6:0], 1'b1})]}, {16'd0, data[31:16]});
      ref_mem[word[5:0]] = data;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    drive(2'd0, 32'd0, 32'd0, 1'b0, 5'd0);

    //            op     addr   data          wb    dest   exp_val
    vecs[0]  = '{2'd0, 32'd5,    32'h0,        1'b1, 5'd7,  32'h0};
    vecs[1]  = '{2'd2, 32'd1028, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0};
    vecs[2]  = '{2'd1, 32'd1028, 32'h0,        1'b1, 5'd3,  32'hDEADBEEF};
    vecs[3]  = '{2'd1, 32'd1028, 32'h0,        1'b1, 5'd4,  32'hDEADBEEF};
    vecs[4]  = '{2'd3, 32'd1024, 32'h12345678, 1'b1, 5'd9,  32'h0};
    vecs[5]  = '{2'd1, 32'd1024, 32'h0,        1'b1, 5'd10, 32'h12345678};
    vecs[6]  = '{2'd2, 32'd1028, 32'h00000000, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{2'd1, 32'd1028, 32'h0,        1'b1, 5'd11, 32'h00000000};
    vecs[8]  = '{2'd2, 32'd1032, 32'hCAFEF00D, 1'b0, 5'd0,  32'h0};
    vecs[9]  = '{2'd1, 32'd1032, 32'h0,        1'b1, 5'd12, 32'hCAFEF00D};
    vecs[10] = '{2'd0, 32'd1032, 32'h0,        1'b0, 5'd31, 32'h0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, pipe.ready}, 32'd1);
    check("rst_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", pipe.mem_read_value, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_access(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].wb, vecs[i].dest, vecs[i].exp_val);

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [5:0]  w;
      logic [31:0] d;
      op = 2'($urandom_range(1, 3));
      w  = 6'($urandom_range(0, 15));
      d  = $urandom;
      run_access(op, BASE + 32'(w) * 4, d, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), ref_mem[w]);
    end

    // Make mem_read_value non-zero, then reset in the middle of a store's HI phase.
    run_access(2'd2, 32'd1036, 32'hA5A55A5A, 1'b0, 5'd0, 32'h0);
    run_access(2'd1, 32'd1036, 32'h0, 1'b1, 5'd1, 32'hA5A55A5A);
    @(posedge clk); #1;
    drive(2'd2, 32'd1044, 32'h0BADF00D, 1'b0, 5'd0);
    begin
      logic seen_hi;
      seen_hi = 1'b0;
      for (int k = 0; k < 20 && !seen_hi; k++) begin
        @(negedge clk);
        if (dbg_state == 2'd2) seen_hi = 1'b1;
      end
      check("reach_hi", {31'd0, seen_hi}, 32'd1);
    end
    check("hi_we_active", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    check("midrst_rdata", pipe.mem_read_value, 32'd0);
    check("midrst_addr", 32'(sram_addr), 32'd0);
    check("midrst_ready", {31'd0, pipe.ready}, 32'd0);
    @(posedge clk); #1;
    drive(2'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    model_reset();
    @(negedge clk);
    check("midrst_idle_ready", {31'd0, pipe.ready}, 32'd1);
    rst = 1'b0;

    run_access(2'd2, 32'd1044, 32'h0BADF00D, 1'b0, 5'd0, 32'h0);
    run_access(2'd1, 32'd1044, 32'h0, 1'b1, 5'd2, 32'h0BADF00D);
    run_access(2'd1, 32'd1028, 32'h0, 1'b1, 5'd2, 32'h0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
